// File: rtl/exa_crosb_vc_pkg.sv
// Shared types, default sizes and VC index helpers for the VC crossbar input and output arbiters.
// A VC index packs priority class and sub-VC as v = prio*vc_num + vc.
package exa_crosb_vc_pkg;

  localparam int VC_NUM     = 3;
  localparam int PRIO_NUM   = 2;
  localparam int OUTPUT_NUM = 8;
  localparam int CREDIT_MAX = 4;

  function automatic int vc_w(input int nv, input int np);
    return $clog2(nv * np);
  endfunction

  function automatic int out_w(input int no);
    return $clog2(no);
  endfunction

  localparam int VC_W  = vc_w(VC_NUM, PRIO_NUM);
  localparam int OUT_W = out_w(OUTPUT_NUM);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2
  } arb_state_e;

  function automatic int vc_pack(input int prio, input int vc, input int nv);
    return prio * nv + vc;
  endfunction

  function automatic int vc_prio(input int v, input int nv);
    return v / nv;
  endfunction

  function automatic int vc_sub(input int v, input int nv);
    return v % nv;
  endfunction

endpackage

// File: rtl/exa_crosb_rr_picker.sv
// Round-robin find-first over N requesters, searching upward from ptr with wrap N-1 -> 0.
// Purely combinational; ptr must stay below N.
module exa_crosb_rr_picker #(
  parameter int N  = 3,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic          gnt_vld,
  output logic [PW-1:0] gnt_idx
);

  logic [PW-1:0] cand [N];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      cand[i] = (int'(ptr) + i >= N) ? PW'(int'(ptr) + i - N) : PW'(int'(ptr) + i);
    end
  end

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (!gnt_vld && req[cand[i]]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand[i];
      end
    end
  end

endmodule

// File: rtl/exa_crosb_input_vc_arbiter.sv
// Per-input VC scheduler: picks an eligible VC, requests its output, streams the packet once granted.
// Select->request 1 cycle; stalls in REQ until granted, bubbles on i_flit_valid low; packet credits per (output, VC).
module exa_crosb_input_vc_arbiter
  import exa_crosb_vc_pkg::*;
#(
  parameter int vc_num     = VC_NUM,
  parameter int prio_num   = PRIO_NUM,
  parameter int output_num = OUTPUT_NUM,
  parameter int credit_max = CREDIT_MAX
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic [vc_num*prio_num-1:0]                    i_vc_valid,
  input  logic [vc_num*prio_num*$clog2(output_num)-1:0] i_vc_dest,
  input  logic                                          i_flit_valid,
  input  logic                                          i_last,
  output logic                                          o_rd_en,
  output logic                                          o_req_valid,
  output logic [$clog2(output_num)-1:0]                 o_req_output,
  output logic [$clog2(vc_num*prio_num)-1:0]            o_req_vc,
  input  logic [output_num-1:0]                         i_grant,
  output logic                                          o_cts,
  input  logic [output_num*vc_num*prio_num-1:0]         i_credit_return,
  output logic                                          o_credit_err
);

  localparam int NV  = vc_num * prio_num;
  localparam int VW  = vc_w(vc_num, prio_num);
  localparam int OW  = out_w(output_num);
  localparam int PW  = (vc_num > 1) ? $clog2(vc_num) : 1;
  localparam int PRW = (prio_num > 1) ? $clog2(prio_num) : 1;
  localparam int CW  = $clog2(credit_max + 1);

  arb_state_e state, state_nxt;

  logic [CW-1:0]  credit [output_num][NV];
  logic [PW-1:0]  rr_ptr [prio_num];
  logic [NV-1:0]  elig;
  logic [prio_num-1:0] cls_vld;
  logic [PW-1:0]  cls_idx [prio_num];
  logic           pick_vld;
  logic [PRW-1:0] pick_prio;
  logic [PW-1:0]  pick_sub;
  logic [VW-1:0]  pick_vc;
  logic [PRW-1:0] sel_prio;
  logic [PW-1:0]  sel_sub;
  logic           gnt_hit;
  logic           last_beat;
  logic [output_num-1:0][NV-1:0] cons;

  // A VC with no downstream credit for its head packet's output is invisible to selection.
  always_comb begin
    for (int v = 0; v < NV; v++) begin
      elig[v] = i_vc_valid[v] && (credit[i_vc_dest[v*OW +: OW]][v] != '0);
    end
  end

  for (genvar p = 0; p < prio_num; p++) begin : g_cls
    exa_crosb_rr_picker #(
      .N  (vc_num),
      .PW (PW)
    ) u_pick (
      .req     (elig[p*vc_num +: vc_num]),
      .ptr     (rr_ptr[p]),
      .gnt_vld (cls_vld[p]),
      .gnt_idx (cls_idx[p])
    );
  end

  // Ascending scan so the highest non-empty class wins.
  always_comb begin
    pick_vld  = 1'b0;
    pick_prio = '0;
    pick_sub  = '0;
    for (int p = 0; p < prio_num; p++) begin
      if (cls_vld[p]) begin
        pick_vld  = 1'b1;
        pick_prio = PRW'(p);
        pick_sub  = cls_idx[p];
      end
    end
  end

  assign pick_vc     = VW'(vc_pack(int'(pick_prio), int'(pick_sub), vc_num));
  assign o_req_valid = (state == REQ);
  assign o_cts       = (state == XFER);
  assign o_rd_en     = o_cts & i_flit_valid;
  assign gnt_hit     = (state == REQ) && i_grant[o_req_output];
  assign last_beat   = o_rd_en && i_last;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_vld)  state_nxt = REQ;
      REQ:     if (gnt_hit)   state_nxt = XFER;
      XFER:    if (last_beat) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Selection is captured only in IDLE, so the request stays fixed until granted.
  always_ff @(posedge clk) begin
    if (reset) begin
      o_req_output <= '0;
      o_req_vc     <= '0;
      sel_prio     <= '0;
      sel_sub      <= '0;
      for (int p = 0; p < prio_num; p++) rr_ptr[p] <= '0;
    end else begin
      if (state == IDLE && pick_vld) begin
        o_req_vc     <= pick_vc;
        o_req_output <= i_vc_dest[int'(pick_vc)*OW +: OW];
        sel_prio     <= pick_prio;
        sel_sub      <= pick_sub;
      end
      if (state == XFER && last_beat) begin
        rr_ptr[sel_prio] <= (sel_sub == PW'(vc_num - 1)) ? '0 : sel_sub + 1'b1;
      end
    end
  end

  always_comb begin
    for (int o = 0; o < output_num; o++) begin
      for (int v = 0; v < NV; v++) begin
        cons[o][v] = gnt_hit && (o_req_output == OW'(o)) && (o_req_vc == VW'(v));
      end
    end
  end

  // Return and consume on one counter cancel; a return onto a full counter is dropped and flagged.
  always_ff @(posedge clk) begin
    if (reset) begin
      o_credit_err <= 1'b0;
      for (int o = 0; o < output_num; o++) begin
        for (int v = 0; v < NV; v++) credit[o][v] <= CW'(credit_max);
      end
    end else begin
      for (int o = 0; o < output_num; o++) begin
        for (int v = 0; v < NV; v++) begin
          if (i_credit_return[o*NV+v] && !cons[o][v]) begin
            if (credit[o][v] == CW'(credit_max)) o_credit_err <= 1'b1;
            else                                 credit[o][v] <= credit[o][v] + 1'b1;
          end else if (cons[o][v] && !i_credit_return[o*NV+v] && credit[o][v] != '0) begin
            credit[o][v] <= credit[o][v] - 1'b1;
          end
        end
      end
    end
  end

endmodule
